// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the register file and its pending-write scoreboard.
package reg_file_pkg;

  localparam int RESET_VAL_W  = 64;
  localparam int R0_PROTECTED = 1;

  function automatic int addr_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  // Architected reset contents: register i holds i, zero-extended.
  function automatic logic [RESET_VAL_W-1:0] resetValue(input int unsigned idx);
    return RESET_VAL_W'(idx);
  endfunction

endpackage

// File: rtl/reg_pend_counter.sv
// Saturating count of outstanding writers for one register; busy reflects registered state.
module reg_pend_counter import reg_file_pkg::*; #(
  parameter int PEND_W      = 2,
  parameter int WRITE_PORTS = 2,
  parameter int DEC_W       = $clog2(WRITE_PORTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic [DEC_W-1:0]  dec_count,
  output logic [PEND_W-1:0] count,
  output logic              busy
);

  localparam int CountMax = (1 << PEND_W) - 1;

  int                sum;
  logic [PEND_W-1:0] countNext;

  always_comb begin
    sum = int'(count) + int'(inc) - int'(dec_count);
    if (sum < 0)
      countNext = '0;
    else if (sum > CountMax)
      countNext = PEND_W'(CountMax);
    else
      countNext = PEND_W'(sum);
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else
      count <= countNext;
  end

  assign busy = (count != '0);

endmodule

// File: rtl/reg_file_sb.sv
// Multi-ported register file with same-cycle write bypass and a per-register pending-write scoreboard.
module reg_file_sb import reg_file_pkg::*; #(
  parameter int WORD_LEN    = 32,
  parameter int WORD_COUNT  = 16,
  parameter int ADDR_W      = addr_w(WORD_COUNT),
  parameter int READ_PORTS  = 3,
  parameter int WRITE_PORTS = 2,
  parameter int PEND_W      = 2,
  parameter int PROTECT_R0  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [READ_PORTS*ADDR_W-1:0]    rd_addr,
  output logic [READ_PORTS*WORD_LEN-1:0]  rd_data,
  output logic [READ_PORTS-1:0]           rd_busy,
  input  logic [WRITE_PORTS-1:0]          wr_en,
  input  logic [WRITE_PORTS*ADDR_W-1:0]   wr_addr,
  input  logic [WRITE_PORTS*WORD_LEN-1:0] wr_data,
  input  logic                            issue_valid,
  input  logic [ADDR_W-1:0]               issue_addr,
  output logic                            issue_ready,
  output logic [WORD_COUNT-1:0]           busy_vec
);

  localparam int                DEC_W   = $clog2(WRITE_PORTS + 1);
  localparam bit                protR0  = (PROTECT_R0 == R0_PROTECTED);
  localparam logic [PEND_W-1:0] pendMax = '1;

  logic [WORD_LEN-1:0] regs     [WORD_COUNT];
  logic [PEND_W-1:0]   pend     [WORD_COUNT];
  logic [DEC_W-1:0]    hitCount [WORD_COUNT];
  logic [WORD_LEN-1:0] winData  [WORD_COUNT];
  logic [WORD_COUNT-1:0] hs;

  logic [ADDR_W-1:0]   wrAddr [WRITE_PORTS];
  logic [WORD_LEN-1:0] wrData [WRITE_PORTS];
  logic [WRITE_PORTS-1:0] wrEff;
  logic [ADDR_W-1:0]   rdAddr [READ_PORTS];

  always_comb begin
    for (int p = 0; p < WRITE_PORTS; p++) begin
      wrAddr[p] = wr_addr[p*ADDR_W +: ADDR_W];
      wrData[p] = wr_data[p*WORD_LEN +: WORD_LEN];
      wrEff[p]  = wr_en[p] && !rst && !(protR0 && wrAddr[p] == '0);
    end
  end

  // NOTE: every always_comb output gets a default before any conditional assignment, so no latches are inferred.
  always_comb begin
    for (int a = 0; a < WORD_COUNT; a++) begin
      hitCount[a] = '0;
      winData[a]  = '0;
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (wrEff[p] && wrAddr[p] == ADDR_W'(a)) begin
          hitCount[a] = hitCount[a] + DEC_W'(1);
          winData[a]  = wrData[p];  // later ports overwrite: highest index wins
        end
      end
    end
  end

  // Reads forward the winning write data; busy looks at the count after this cycle's write-backs.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < READ_PORTS; k++) begin
      rdAddr[k] = rd_addr[k*ADDR_W +: ADDR_W];
      if (hitCount[rdAddr[k]] != '0)
        rd_data[k*WORD_LEN +: WORD_LEN] = winData[rdAddr[k]];
      else
        rd_data[k*WORD_LEN +: WORD_LEN] = regs[rdAddr[k]];
      rd_busy[k] = int'(pend[rdAddr[k]]) > int'(hitCount[rdAddr[k]]);
    end
  end

  always_comb begin
    issue_ready = 1'b0;
    if (!rst)
      issue_ready = (protR0 && issue_addr == '0) || (pend[issue_addr] != pendMax);
    hs = '0;
    if (issue_valid && issue_ready && !(protR0 && issue_addr == '0))
      hs[issue_addr] = 1'b1;
  end

  // NOTE: the array is reset element by element because its reset contents are architected state, which keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < WORD_COUNT; a++)
        regs[a] <= WORD_LEN'(resetValue(a));
    end else begin
      for (int a = 0; a < WORD_COUNT; a++)
        if (hitCount[a] != '0)
          regs[a] <= winData[a];
    end
  end

  for (genvar a = 0; a < WORD_COUNT; a++) begin : gPend
    reg_pend_counter #(
      .PEND_W      (PEND_W),
      .WRITE_PORTS (WRITE_PORTS),
      .DEC_W       (DEC_W)
    ) uCounter (
      .clk       (clk),
      .rst       (rst),
      .inc       (hs[a]),
      .dec_count (hitCount[a]),
      .count     (pend[a]),
      .busy      (busy_vec[a])
    );
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scenarios plus randomized traffic against a behavioural register-file/scoreboard model.
module tb_reg_file_sb;

  localparam int WL = 32;
  localparam int WC = 16;
  localparam int AW = 4;
  localparam int RP = 3;
  localparam int WP = 2;
  localparam int PEND_MAX = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [RP*AW-1:0] rd_addr;
  logic [RP*WL-1:0] rd_data;
  logic [RP-1:0]    rd_busy;
  logic [WP-1:0]    wr_en;
  logic [WP*AW-1:0] wr_addr;
  logic [WP*WL-1:0] wr_data;
  logic             issue_valid;
  logic [AW-1:0]    issue_addr;
  logic             issue_ready;
  logic [WC-1:0]    busy_vec;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mRegs [WC];
  int          mPend [WC];

  reg_file_sb #(
    .WORD_LEN(WL), .WORD_COUNT(WC), .ADDR_W(AW), .READ_PORTS(RP),
    .WRITE_PORTS(WP), .PEND_W(2), .PROTECT_R0(1)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_valid(issue_valid),
    .issue_addr(issue_addr), .issue_ready(issue_ready), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  function automatic int wa(int p);
    return int'(wr_addr[p*AW +: AW]);
  endfunction

  function automatic logic [31:0] wd(int p);
    return wr_data[p*WL +: WL];
  endfunction

  function automatic logic [31:0] rdPort(int k);
    return rd_data[k*WL +: WL];
  endfunction

  function automatic bit effWrite(int p);
    return wr_en[p] && !rst && wa(p) != 0;
  endfunction

  function automatic int hitsOn(int a);
    int n = 0;
    for (int p = 0; p < WP; p++)
      if (effWrite(p) && wa(p) == a) n++;
    return n;
  endfunction

  function automatic logic [31:0] expData(int a);
    logic [31:0] v = mRegs[a];
    for (int p = 0; p < WP; p++)
      if (effWrite(p) && wa(p) == a) v = wd(p);
    return v;
  endfunction

  function automatic bit expBusy(int a);
    return (mPend[a] - hitsOn(a)) > 0;
  endfunction

  function automatic bit expReady();
    return !rst && (issue_addr == 0 || mPend[int'(issue_addr)] != PEND_MAX);
  endfunction

  task automatic setRead(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic setWrite(input int p, input int a, input logic [31:0] d);
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*WL +: WL] = d;
  endtask

  task automatic idle();
    wr_en = '0;
    issue_valid = 1'b0;
  endtask

  // Commit this cycle's inputs to the model at the rising edge, then return at the falling edge.
  task automatic step();
    logic [31:0] nRegs [WC];
    int nPend [WC];
    int v;
    bit hs;
    for (int a = 0; a < WC; a++) begin
      if (rst) begin
        nRegs[a] = 32'(a);
        nPend[a] = 0;
      end else begin
        nRegs[a] = expData(a);
        hs = issue_valid && expReady() && int'(issue_addr) == a && a != 0;
        v = mPend[a] + int'(hs) - hitsOn(a);
        nPend[a] = (v < 0) ? 0 : (v > PEND_MAX) ? PEND_MAX : v;
      end
    end
    @(posedge clk);
    for (int a = 0; a < WC; a++) begin
      mRegs[a] = nRegs[a];
      mPend[a] = nPend[a];
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_en = 2'b11;
    setWrite(0, 5, 32'hFFFF_FFFF);
    setWrite(1, 6, 32'hFFFF_FFFF);
    issue_valid = 1'b1;
    issue_addr = 4'd2;
    #1;
    vectors++;
    if (issue_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_issue_ready: got %b expected 0", issue_ready);
    end
    step();
    vectors++;
    if (busy_vec !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_busy_vec: got %h expected 0000", busy_vec);
    end
    rst = 1'b0;
    idle();
    for (int i = 0; i < WC; i++) begin
      for (int k = 0; k < RP; k++) setRead(k, i);
      #1;
      for (int k = 0; k < RP; k++) begin
        vectors++;
        if (rdPort(k) !== 32'(i)) begin
          miscompares++;
          $display("FAIL reset_rd_data r%0d port%0d: got %h expected %h", i, k, rdPort(k), 32'(i));
        end
      end
    end
  endtask

  task automatic test_bypass();
    idle();
    setRead(1, 3);
    wr_en = 2'b01;
    setWrite(0, 3, 32'hDEAD_BEEF);
    #1;
    vectors++;
    if (rdPort(1) !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL bypass_same_cycle: got %h expected deadbeef", rdPort(1));
    end
    step();
    idle();
    #1;
    vectors++;
    if (rdPort(1) !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL bypass_stored: got %h expected deadbeef", rdPort(1));
    end
  endtask

  task automatic test_priority();
    idle();
    wr_en = 2'b11;
    setWrite(0, 7, 32'h11);
    setWrite(1, 7, 32'h22);
    setRead(0, 7);
    #1;
    vectors++;
    if (rdPort(0) !== 32'h22) begin
      miscompares++;
      $display("FAIL priority_bypass: got %h expected 00000022", rdPort(0));
    end
    step();
    idle();
    #1;
    vectors++;
    if (rdPort(0) !== 32'h22) begin
      miscompares++;
      $display("FAIL priority_stored: got %h expected 00000022", rdPort(0));
    end
    wr_en = 2'b01;
    setWrite(0, 0, 32'hFF);
    setRead(2, 0);
    #1;
    vectors++;
    if (rdPort(2) !== 32'h0) begin
      miscompares++;
      $display("FAIL r0_no_bypass: got %h expected 00000000", rdPort(2));
    end
    step();
    idle();
    #1;
    vectors++;
    if (rdPort(2) !== 32'h0) begin
      miscompares++;
      $display("FAIL r0_protected: got %h expected 00000000", rdPort(2));
    end
  endtask

  task automatic test_scoreboard();
    idle();
    issue_addr = 4'd4;
    setRead(0, 4);
    for (int n = 0; n < 3; n++) begin
      issue_valid = 1'b1;
      #1;
      vectors++;
      if (issue_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL sb_issue_ready_%0d: got %b expected 1", n, issue_ready);
      end
      step();
    end
    #1;
    vectors++;
    if (issue_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_saturated_ready: got %b expected 0", issue_ready);
    end
    vectors++;
    if (busy_vec[4] !== 1'b1 || rd_busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_busy_r4: got busy_vec=%b rd_busy=%b expected 1 1", busy_vec[4], rd_busy[0]);
    end
    step();
    issue_valid = 1'b0;
    wr_en = 2'b01;
    setWrite(0, 4, 32'h44);
    #1;
    vectors++;
    if (rd_busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_wb_still_busy: got %b expected 1", rd_busy[0]);
    end
    step();
    idle();
    #1;
    vectors++;
    if (issue_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_ready_after_wb: got %b expected 1", issue_ready);
    end
    issue_valid = 1'b1;
    wr_en = 2'b01;
    #1;
    vectors++;
    if (issue_ready !== 1'b1 || rd_busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_issue_and_wb: got ready=%b rd_busy=%b expected 1 1", issue_ready, rd_busy[0]);
    end
    step();
    idle();
    wr_en = 2'b11;
    setWrite(1, 4, 32'h45);
    #1;
    vectors++;
    if (rd_busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_double_wb_probe: got %b expected 0", rd_busy[0]);
    end
    wr_en = 2'b00;
    #1;
    vectors++;
    if (rd_busy[0] !== 1'b1 || issue_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_pend_two: got rd_busy=%b ready=%b expected 1 1", rd_busy[0], issue_ready);
    end
  endtask

  task automatic test_release();
    idle();
    issue_addr = 4'd9;
    issue_valid = 1'b1;
    setRead(1, 9);
    #1;
    step();
    issue_valid = 1'b0;
    #1;
    vectors++;
    if (busy_vec[9] !== 1'b1 || rd_busy[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL rel_reserved: got busy_vec=%b rd_busy=%b expected 1 1", busy_vec[9], rd_busy[1]);
    end
    wr_en = 2'b01;
    setWrite(0, 9, 32'h99);
    #1;
    vectors++;
    if (rd_busy[1] !== 1'b0 || busy_vec[9] !== 1'b1) begin
      miscompares++;
      $display("FAIL rel_wb_cycle: got rd_busy=%b busy_vec=%b expected 0 1", rd_busy[1], busy_vec[9]);
    end
    step();
    idle();
    #1;
    vectors++;
    if (busy_vec[9] !== 1'b0 || rdPort(1) !== 32'h99) begin
      miscompares++;
      $display("FAIL rel_after: got busy_vec=%b data=%h expected 0 00000099", busy_vec[9], rdPort(1));
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    wr_en = 2'b01;
    setWrite(0, 5, 32'hABCD);
    issue_valid = 1'b1;
    issue_addr = 4'd6;
    #1;
    vectors++;
    if (issue_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_ready: got %b expected 0", issue_ready);
    end
    step();
    rst = 1'b0;
    idle();
    issue_addr = 4'd4;
    setRead(0, 5);
    setRead(1, 4);
    #1;
    vectors++;
    if (busy_vec !== 16'h0 || rd_busy[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_busy: got busy_vec=%h rd_busy=%b expected 0000 0", busy_vec, rd_busy[1]);
    end
    vectors++;
    if (rdPort(0) !== 32'h5) begin
      miscompares++;
      $display("FAIL midrst_write_discarded: got %h expected 00000005", rdPort(0));
    end
  endtask

  task automatic test_random();
    logic [WC-1:0] expVec;
    int a;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < RP; k++) setRead(k, $urandom_range(0, 15));
      for (int p = 0; p < WP; p++) begin
        wr_en[p] = ($urandom_range(0, 2) == 0);
        setWrite(p, $urandom_range(0, 7), $urandom);
      end
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_addr = AW'($urandom_range(0, 7));
      #1;
      for (int k = 0; k < RP; k++) begin
        a = int'(rd_addr[k*AW +: AW]);
        vectors++;
        if (rdPort(k) !== expData(a)) begin
          miscompares++;
          $display("FAIL rnd_rd_data cyc%0d port%0d r%0d: got %h expected %h", cyc, k, a, rdPort(k), expData(a));
        end
        vectors++;
        if (rd_busy[k] !== expBusy(a)) begin
          miscompares++;
          $display("FAIL rnd_rd_busy cyc%0d port%0d r%0d: got %b expected %b", cyc, k, a, rd_busy[k], expBusy(a));
        end
      end
      vectors++;
      if (issue_ready !== expReady()) begin
        miscompares++;
        $display("FAIL rnd_issue_ready cyc%0d: got %b expected %b", cyc, issue_ready, expReady());
      end
      for (int i = 0; i < WC; i++) expVec[i] = (mPend[i] != 0);
      vectors++;
      if (busy_vec !== expVec) begin
        miscompares++;
        $display("FAIL rnd_busy_vec cyc%0d: got %h expected %h", cyc, busy_vec, expVec);
      end
      step();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    issue_valid = 1'b0;
    issue_addr = '0;
    test_reset();
    test_bypass();
    test_priority();
    test_scoreboard();
    test_release();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
